// File: rtl/lsu_ctrl_mo_pkg.sv
// Shared definitions for the multiple-outstanding LSU controller: access size
// encodings and the tracking-FIFO entry width.
package lsu_ctrl_mo_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2,
    LSU_SIZE_D = 2'd3
  } lsu_size_e;

  // Entry layout, MSB first: read, itag, addr_lo, size, usign.
  function automatic int unsigned lsu_entry_width(input int unsigned xlen,
                                                  input int unsigned itag_w);
    return 1 + itag_w + $clog2(xlen / 8) + 2 + 1;
  endfunction

endpackage

// File: rtl/lsu_ctrl_mo_outs_fifo.sv
// In-order tracking FIFO for outstanding LSU transactions. Synchronous
// active-high reset; push is ignored when full, pop is ignored when empty.
module lsu_outs_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_en, pop_en;

  assign full_o  = (cnt_q == CW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + PW'(1);
      if (pop_en)  rptr_q <= rptr_q + PW'(1);
      unique case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/lsu_ctrl_mo.sv
// Multiple-outstanding load/store controller between AGU and DTCM: forwards
// commands with zero latency and routes in-order responses by tracked metadata.
module lsu_ctrl_mo
  import lsu_ctrl_mo_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AW         = 16,
  parameter int unsigned ITAG_W     = 3,
  parameter int unsigned OUTS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          agu_cmd_valid,
  output logic                          agu_cmd_ready,
  input  logic                          agu_cmd_read,
  input  logic [AW-1:0]                 agu_cmd_addr,
  input  logic [XLEN-1:0]               agu_cmd_wdata,
  input  logic [XLEN/8-1:0]             agu_cmd_wmask,
  input  logic [1:0]                    agu_cmd_size,
  input  logic                          agu_cmd_usign,
  input  logic [ITAG_W-1:0]             agu_cmd_itag,
  output logic                          agu_rsp_valid,
  input  logic                          agu_rsp_ready,
  output logic                          dtcm_cmd_valid,
  input  logic                          dtcm_cmd_ready,
  output logic                          dtcm_cmd_read,
  output logic [AW-1:0]                 dtcm_cmd_addr,
  output logic [XLEN-1:0]               dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]             dtcm_cmd_wmask,
  input  logic                          dtcm_rsp_valid,
  output logic                          dtcm_rsp_ready,
  input  logic [XLEN-1:0]               dtcm_rsp_rdata,
  output logic                          lsu_o_valid,
  input  logic                          lsu_o_ready,
  output logic [XLEN-1:0]               lsu_o_wbck_data,
  output logic [ITAG_W-1:0]             lsu_o_wbck_itag,
  output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
  output logic                          lsu_idle,
  output logic                          rsp_err
);

  localparam int unsigned LW = $clog2(XLEN / 8);
  localparam int unsigned EW = lsu_entry_width(XLEN, ITAG_W);

  logic [EW-1:0]     entry_in, head;
  logic              full, empty, push, pop;
  logic              head_read, head_usign;
  logic [ITAG_W-1:0] head_itag;
  logic [LW-1:0]     head_addr_lo, lo_aligned;
  logic [1:0]        head_size;
  logic [XLEN-1:0]   d, wbck;
  logic              sign;
  int                nbits;
  logic              rsp_err_q;

  // Full comes from the registered count only, so a same-cycle pop never
  // feeds back into command ready.
  assign dtcm_cmd_valid = agu_cmd_valid & ~full & ~rst;
  assign agu_cmd_ready  = dtcm_cmd_ready & ~full & ~rst;
  assign dtcm_cmd_read  = agu_cmd_read;
  assign dtcm_cmd_addr  = agu_cmd_addr;
  assign dtcm_cmd_wdata = agu_cmd_wdata;
  assign dtcm_cmd_wmask = agu_cmd_wmask;
  assign push           = agu_cmd_valid & agu_cmd_ready;

  assign entry_in = {agu_cmd_read, agu_cmd_itag, agu_cmd_addr[LW-1:0], agu_cmd_size,
                     agu_cmd_usign};
  assign {head_read, head_itag, head_addr_lo, head_size, head_usign} = head;

  lsu_outs_fifo #(
    .Width (EW),
    .Depth (OUTS_DEPTH)
  ) u_outs_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (entry_in),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (outs_cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  assign lsu_o_valid    = dtcm_rsp_valid & ~empty & head_read;
  assign agu_rsp_valid  = dtcm_rsp_valid & ~empty & ~head_read;
  assign dtcm_rsp_ready = ~empty & (head_read ? lsu_o_ready : agu_rsp_ready);
  assign pop            = dtcm_rsp_valid & dtcm_rsp_ready;

  assign lsu_o_wbck_itag = head_itag;
  assign lsu_o_wbck_data = wbck;
  assign lsu_idle        = (outs_cnt == '0);
  assign rsp_err         = rsp_err_q;

  always_comb begin
    // Misaligned low address bits are dropped down to the access size.
    lo_aligned = head_addr_lo;
    for (int i = 0; i < int'(LW); i++) begin
      if (i < int'(head_size)) lo_aligned[i] = 1'b0;
    end
    d = dtcm_rsp_rdata >> {lo_aligned, 3'b000};
    case (lsu_size_e'(head_size))
      LSU_SIZE_B: begin nbits = 8;  sign = d[7];  end
      LSU_SIZE_H: begin nbits = 16; sign = d[15]; end
      LSU_SIZE_W: begin nbits = 32; sign = d[31]; end
      default:    begin nbits = int'(XLEN); sign = 1'b0; end
    endcase
    wbck = d;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i >= nbits) wbck[i] = sign & ~head_usign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (dtcm_rsp_valid & empty) begin
      rsp_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl_mo.sv
// Self-checking bench for lsu_ctrl_mo: directed scenarios plus a randomized
// stream compared against a queue-based transaction model.
module tb_lsu_ctrl_mo;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [15:0] agu_cmd_addr;
  logic [31:0] agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask;
  logic [1:0]  agu_cmd_size;
  logic [2:0]  agu_cmd_itag;
  logic        agu_rsp_valid, agu_rsp_ready;
  logic        dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [15:0] dtcm_cmd_addr;
  logic [31:0] dtcm_cmd_wdata;
  logic [3:0]  dtcm_cmd_wmask;
  logic        dtcm_rsp_valid, dtcm_rsp_ready;
  logic [31:0] dtcm_rsp_rdata;
  logic        lsu_o_valid, lsu_o_ready;
  logic [31:0] lsu_o_wbck_data;
  logic [2:0]  lsu_o_wbck_itag;
  logic [2:0]  outs_cnt;
  logic        lsu_idle, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit        read;
    bit [2:0]  itag;
    bit [15:0] addr;
    bit [1:0]  size;
    bit        usign;
    bit [31:0] rdata;
  } txn_t;

  txn_t q[$];

  always #5 clk = ~clk;

  lsu_ctrl_mo #(
    .XLEN       (32),
    .AW         (16),
    .ITAG_W     (3),
    .OUTS_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .agu_cmd_valid   (agu_cmd_valid),
    .agu_cmd_ready   (agu_cmd_ready),
    .agu_cmd_read    (agu_cmd_read),
    .agu_cmd_addr    (agu_cmd_addr),
    .agu_cmd_wdata   (agu_cmd_wdata),
    .agu_cmd_wmask   (agu_cmd_wmask),
    .agu_cmd_size    (agu_cmd_size),
    .agu_cmd_usign   (agu_cmd_usign),
    .agu_cmd_itag    (agu_cmd_itag),
    .agu_rsp_valid   (agu_rsp_valid),
    .agu_rsp_ready   (agu_rsp_ready),
    .dtcm_cmd_valid  (dtcm_cmd_valid),
    .dtcm_cmd_ready  (dtcm_cmd_ready),
    .dtcm_cmd_read   (dtcm_cmd_read),
    .dtcm_cmd_addr   (dtcm_cmd_addr),
    .dtcm_cmd_wdata  (dtcm_cmd_wdata),
    .dtcm_cmd_wmask  (dtcm_cmd_wmask),
    .dtcm_rsp_valid  (dtcm_rsp_valid),
    .dtcm_rsp_ready  (dtcm_rsp_ready),
    .dtcm_rsp_rdata  (dtcm_rsp_rdata),
    .lsu_o_valid     (lsu_o_valid),
    .lsu_o_ready     (lsu_o_ready),
    .lsu_o_wbck_data (lsu_o_wbck_data),
    .lsu_o_wbck_itag (lsu_o_wbck_itag),
    .outs_cnt        (outs_cnt),
    .lsu_idle        (lsu_idle),
    .rsp_err         (rsp_err)
  );

  // Reference load result: pick the naturally aligned lane, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [15:0] addr,
                                           input logic [1:0] size, input logic usign);
    int          nbytes = 1 << size;
    int          off    = (int'(addr) % 4) / nbytes * nbytes;
    logic [31:0] v      = rdata >> (off * 8);
    logic [31:0] mask;
    if (nbytes >= 4) return v;
    mask = (32'h1 << (nbytes * 8)) - 32'h1;
    v    = v & mask;
    if (!usign && v[nbytes*8-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    agu_cmd_valid  = 1'b0;
    agu_cmd_read   = 1'b0;
    agu_cmd_addr   = '0;
    agu_cmd_wdata  = '0;
    agu_cmd_wmask  = '0;
    agu_cmd_size   = '0;
    agu_cmd_usign  = 1'b0;
    agu_cmd_itag   = '0;
    agu_rsp_ready  = 1'b0;
    dtcm_cmd_ready = 1'b1;
    dtcm_rsp_valid = 1'b0;
    dtcm_rsp_rdata = '0;
    lsu_o_ready    = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one command; the command must be accepted in its first cycle.
  task automatic issue(input logic rd, input logic [15:0] addr, input logic [1:0] size,
                       input logic us, input logic [2:0] tag);
    @(negedge clk);
    agu_cmd_valid = 1'b1;
    agu_cmd_read  = rd;
    agu_cmd_addr  = addr;
    agu_cmd_size  = size;
    agu_cmd_usign = us;
    agu_cmd_itag  = tag;
    agu_cmd_wdata = $urandom;
    agu_cmd_wmask = 4'hf;
    #1;
    n_tests++;
    if (agu_cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: got %b want 1", agu_cmd_ready);
    end
    @(negedge clk);
    agu_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    agu_cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (outs_cnt !== 3'd0 || lsu_idle !== 1'b1 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d idle=%b err=%b want 0/1/0", outs_cnt, lsu_idle, rsp_err);
    end
    n_tests++;
    if (dtcm_cmd_valid !== 1'b0 || agu_cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cmd_block: dv=%b ar=%b want 0/0", dtcm_cmd_valid, agu_cmd_ready);
    end
    n_tests++;
    if (lsu_o_valid !== 1'b0 || agu_rsp_valid !== 1'b0 || dtcm_rsp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: lv=%b av=%b rr=%b want 0/0/0", lsu_o_valid, agu_rsp_valid,
               dtcm_rsp_ready);
    end
    agu_cmd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    issue(1'b1, 16'h0003, 2'd0, 1'b0, 3'd5);
    #1;
    n_tests++;
    if (outs_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL single_cnt1: got %0d want 1", outs_cnt);
    end
    dtcm_rsp_valid = 1'b1;
    dtcm_rsp_rdata = 32'h80FF_0000;
    lsu_o_ready    = 1'b1;
    #1;
    n_tests++;
    if (lsu_o_valid !== 1'b1 || agu_rsp_valid !== 1'b0 || lsu_o_wbck_data !== 32'hFFFF_FF80 ||
        lsu_o_wbck_itag !== 3'd5) begin
      n_fail++;
      $display("FAIL single_wb: lv=%b av=%b data=%h itag=%0d want 1/0/ffffff80/5", lsu_o_valid,
               agu_rsp_valid, lsu_o_wbck_data, lsu_o_wbck_itag);
    end
    @(negedge clk);
    dtcm_rsp_valid = 1'b0;
    #1;
    n_tests++;
    if (outs_cnt !== 3'd0 || lsu_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cnt0: cnt=%0d idle=%b want 0/1", outs_cnt, lsu_idle);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) issue(1'b1, 16'h0000, 2'd2, 1'b0, 3'(i));
    agu_cmd_valid = 1'b1;
    #1;
    n_tests++;
    if (agu_cmd_ready !== 1'b0 || dtcm_cmd_valid !== 1'b0 || outs_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_full: ar=%b dv=%b cnt=%0d want 0/0/4", agu_cmd_ready, dtcm_cmd_valid,
               outs_cnt);
    end
    agu_cmd_valid = 1'b0;
    lsu_o_ready   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      dtcm_rsp_valid = 1'b1;
      dtcm_rsp_rdata = 32'h1000_0000 * i + 32'h55;
      #1;
      n_tests++;
      if (lsu_o_valid !== 1'b1 || lsu_o_wbck_itag !== 3'(i) ||
          lsu_o_wbck_data !== 32'h1000_0000 * i + 32'h55) begin
        n_fail++;
        $display("FAIL b2b_wb%0d: lv=%b itag=%0d data=%h", i, lsu_o_valid, lsu_o_wbck_itag,
                 lsu_o_wbck_data);
      end
    end
    @(negedge clk);
    dtcm_rsp_valid = 1'b0;
    #1;
    n_tests++;
    if (outs_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d want 0", outs_cnt);
    end
  endtask

  task automatic test_mixed_store_block();
    lsu_o_ready   = 1'b1;
    agu_rsp_ready = 1'b0;
    issue(1'b1, 16'h0001, 2'd0, 1'b1, 3'd1);
    issue(1'b0, 16'h0010, 2'd2, 1'b0, 3'd2);
    issue(1'b1, 16'h0020, 2'd2, 1'b0, 3'd3);
    dtcm_rsp_valid = 1'b1;
    dtcm_rsp_rdata = 32'h0000_AB00;
    #1;
    n_tests++;
    if (lsu_o_valid !== 1'b1 || lsu_o_wbck_data !== 32'h0000_00AB || lsu_o_wbck_itag !== 3'd1) begin
      n_fail++;
      $display("FAIL mixed_ld1: lv=%b data=%h itag=%0d want 1/000000ab/1", lsu_o_valid,
               lsu_o_wbck_data, lsu_o_wbck_itag);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dtcm_rsp_rdata = 32'hCAFE_0000;
      #1;
      n_tests++;
      if (lsu_o_valid !== 1'b0 || agu_rsp_valid !== 1'b1 || dtcm_rsp_ready !== 1'b0 ||
          outs_cnt !== 3'd2) begin
        n_fail++;
        $display("FAIL mixed_blocked: lv=%b av=%b rr=%b cnt=%0d want 0/1/0/2", lsu_o_valid,
                 agu_rsp_valid, dtcm_rsp_ready, outs_cnt);
      end
    end
    agu_rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (dtcm_rsp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_st_rel: got %b want 1", dtcm_rsp_ready);
    end
    @(negedge clk);
    agu_rsp_ready  = 1'b0;
    dtcm_rsp_rdata = 32'h1234_5678;
    #1;
    n_tests++;
    if (lsu_o_valid !== 1'b1 || lsu_o_wbck_itag !== 3'd3 || lsu_o_wbck_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL mixed_ld2: lv=%b itag=%0d data=%h want 1/3/12345678", lsu_o_valid,
               lsu_o_wbck_itag, lsu_o_wbck_data);
    end
    @(negedge clk);
    dtcm_rsp_valid = 1'b0;
    #1;
    n_tests++;
    if (outs_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL mixed_drain: got %0d want 0", outs_cnt);
    end
  endtask

  task automatic test_half_load();
    lsu_o_ready = 1'b1;
    issue(1'b1, 16'h0002, 2'd1, 1'b1, 3'd6);
    dtcm_rsp_valid = 1'b1;
    dtcm_rsp_rdata = 32'hBEEF_1234;
    #1;
    n_tests++;
    if (lsu_o_valid !== 1'b1 || lsu_o_wbck_data !== 32'h0000_BEEF || lsu_o_wbck_itag !== 3'd6) begin
      n_fail++;
      $display("FAIL half_load: lv=%b data=%h itag=%0d want 1/0000beef/6", lsu_o_valid,
               lsu_o_wbck_data, lsu_o_wbck_itag);
    end
    @(negedge clk);
    dtcm_rsp_valid = 1'b0;
  endtask

  task automatic test_empty_rsp_err();
    @(negedge clk);
    lsu_o_ready    = 1'b1;
    agu_rsp_ready  = 1'b1;
    dtcm_rsp_valid = 1'b1;
    #1;
    n_tests++;
    if (dtcm_rsp_ready !== 1'b0 || lsu_o_valid !== 1'b0 || agu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_accept: rr=%b lv=%b av=%b want 0/0/0", dtcm_rsp_ready, lsu_o_valid,
               agu_rsp_valid);
    end
    @(negedge clk);
    dtcm_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", rsp_err);
    end
    pulse_reset();
    #1;
    n_tests++;
    if (rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", rsp_err);
    end
  endtask

  task automatic test_reset_inflight();
    lsu_o_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(1'b1, 16'h0004, 2'd2, 1'b0, 3'(i));
    #1;
    n_tests++;
    if (outs_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_pre_cnt: got %0d want 3", outs_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dtcm_rsp_valid = 1'b1;
    #1;
    n_tests++;
    if (outs_cnt !== 3'd0 || lsu_idle !== 1'b1 || lsu_o_valid !== 1'b0 ||
        agu_rsp_valid !== 1'b0 || dtcm_rsp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_inflight: cnt=%0d idle=%b lv=%b av=%b rr=%b want 0/1/0/0/0", outs_cnt,
               lsu_idle, lsu_o_valid, agu_rsp_valid, dtcm_rsp_ready);
    end
    @(negedge clk);
    dtcm_rsp_valid = 1'b0;
    pulse_reset();
  endtask

  task automatic test_random();
    txn_t cand;
    bit   exp_acc, exp_pop, exp_full;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      agu_cmd_valid  = ($urandom_range(0, 2) != 0);
      agu_cmd_read   = $urandom_range(0, 1);
      agu_cmd_addr   = 16'($urandom);
      agu_cmd_size   = 2'($urandom_range(0, 2));
      agu_cmd_usign  = $urandom_range(0, 1);
      agu_cmd_itag   = 3'($urandom);
      agu_cmd_wdata  = $urandom;
      agu_cmd_wmask  = 4'($urandom);
      dtcm_cmd_ready = ($urandom_range(0, 3) != 0);
      lsu_o_ready    = $urandom_range(0, 1);
      agu_rsp_ready  = $urandom_range(0, 1);
      dtcm_rsp_valid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      dtcm_rsp_rdata = (q.size() > 0) ? q[0].rdata : $urandom;
      cand = '{read: agu_cmd_read, itag: agu_cmd_itag, addr: agu_cmd_addr, size: agu_cmd_size,
               usign: agu_cmd_usign, rdata: $urandom};
      exp_full = (q.size() == 4);
      exp_acc  = agu_cmd_valid && dtcm_cmd_ready && !exp_full;
      exp_pop  = dtcm_rsp_valid && (q[0].read ? lsu_o_ready : agu_rsp_ready);
      #1;
      n_tests++;
      if (agu_cmd_ready !== (dtcm_cmd_ready && !exp_full) ||
          dtcm_cmd_valid !== (agu_cmd_valid && !exp_full) ||
          outs_cnt !== 3'(q.size()) || lsu_idle !== (q.size() == 0) ||
          dtcm_cmd_addr !== agu_cmd_addr || dtcm_cmd_wdata !== agu_cmd_wdata ||
          dtcm_cmd_wmask !== agu_cmd_wmask || dtcm_cmd_read !== agu_cmd_read) begin
        n_fail++;
        $display("FAIL rand_cmd c%0d: ar=%b dv=%b cnt=%0d want cnt %0d", cyc, agu_cmd_ready,
                 dtcm_cmd_valid, outs_cnt, q.size());
      end
      if (dtcm_rsp_valid) begin
        n_tests++;
        if (lsu_o_valid !== q[0].read || agu_rsp_valid !== !q[0].read ||
            dtcm_rsp_ready !== exp_pop) begin
          n_fail++;
          $display("FAIL rand_route c%0d: lv=%b av=%b rr=%b want rd=%b pop=%b", cyc, lsu_o_valid,
                   agu_rsp_valid, dtcm_rsp_ready, q[0].read, exp_pop);
        end
        if (q[0].read) begin
          n_tests++;
          if (lsu_o_wbck_data !== ref_load(q[0].rdata, q[0].addr, q[0].size, q[0].usign) ||
              lsu_o_wbck_itag !== q[0].itag) begin
            n_fail++;
            $display("FAIL rand_wb c%0d: data=%h itag=%0d want %h/%0d", cyc, lsu_o_wbck_data,
                     lsu_o_wbck_itag, ref_load(q[0].rdata, q[0].addr, q[0].size, q[0].usign),
                     q[0].itag);
          end
        end
      end
      @(posedge clk);
      if (exp_pop) void'(q.pop_front());
      if (exp_acc) q.push_back(cand);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++;
    if (rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_no_err: got %b want 0", rsp_err);
    end
    pulse_reset();
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_mixed_store_block();
    idle_inputs();
    test_half_load();
    idle_inputs();
    test_empty_rsp_err();
    idle_inputs();
    test_reset_inflight();
    idle_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
